// File: rtl/stage_fetch1_pkg.sv
// Shared fetch-stage types: fault codes, queue entry layout and queue depth.
package stage_fetch1_pkg;

  localparam int FE1_QDEPTH  = 2;
  localparam int FE1_FAULT_W = 2;

  typedef enum logic [FE1_FAULT_W-1:0] {
    FAULT_NONE   = 2'd0,
    FAULT_ACCESS = 2'd1,
    FAULT_PAGE   = 2'd2
  } fe_fault_e;

  typedef struct packed {
    logic [31:0] insn;
    logic [29:0] pc;
    logic        spec;
    fe_fault_e   fault;
  } fe_entry_t;

endpackage

// File: rtl/stage_fetch1_queue.sv
// Two-entry in-order queue of fetched entries with push, pop and synchronous clear.
module stage_fetch1_queue
  import stage_fetch1_pkg::*;
(
  input  logic      clk_core,
  input  logic      reset_n,
  input  logic      push,
  input  fe_entry_t push_entry,
  input  logic      pop,
  input  logic      clear,
  output fe_entry_t head,
  output logic [1:0] count
);

  fe_entry_t mem [FE1_QDEPTH];
  logic      rd_ptr;
  logic      wr_ptr;

  assign head = mem[rd_ptr];

  // Entries are cleared at reset so the head reads as all-zero before the first push.
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      for (int i = 0; i < FE1_QDEPTH; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (clear) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stage_fetch1.sv
// Fetch stage 1: tracks the outstanding icache request, queues responses for decode,
// and drops wrong-path responses after a redirect. Optional counters under FE1_PERF_EN.
module stage_fetch1
  import stage_fetch1_pkg::*;
#(
  parameter int QDEPTH  = FE1_QDEPTH,
  parameter int FAULT_W = FE1_FAULT_W
) (
  input  logic               clk_core,
  input  logic               reset_n,
`ifdef FE1_PERF_EN
  output logic [31:0]        fe1_perf_insn,
  output logic [31:0]        fe1_perf_stall,
`endif
  input  logic               fe0_valid,
  input  logic               fe0_speculative,
  input  logic [29:0]        fe0_read_addr,
  output logic               fe1_stall,
  input  logic               icache_ready,
  input  logic [31:0]        icache_data,
  input  logic [FAULT_W-1:0] icache_fault,
  output logic               fe1_valid,
  output logic [31:0]        fe1_insn,
  output logic [29:0]        fe1_pc,
  output logic               fe1_speculative,
  output logic [FAULT_W-1:0] fe1_fault,
  input  logic               de_stall,
  input  logic               de_setpc,
  input  logic               csr_setpc
);

  logic        flush;
  logic        resp;
  logic        push;
  logic        pop;
  logic        pending_p1;
  logic        drop_p1;
  logic        req_spec_p1;
  logic [29:0] req_pc_p1;
  logic [1:0]  count;
  logic [2:0]  occ_next;
  fe_entry_t   head;
  fe_entry_t   push_entry;

  assign flush = de_setpc | csr_setpc;
  assign resp  = pending_p1 & icache_ready;
  assign push  = resp & ~drop_p1 & ~flush;
  assign pop   = fe1_valid & ~de_stall & ~flush;

  // Occupancy ignores flush here; the stall term masks it instead.
  assign occ_next  = {1'b0, count} - {2'b00, pop} + {2'b00, resp & ~drop_p1};
  assign fe1_stall = (pending_p1 & ~icache_ready) | (~flush & (occ_next >= 3'(QDEPTH)));

  assign push_entry.insn  = icache_data;
  assign push_entry.pc    = req_pc_p1;
  assign push_entry.spec  = req_spec_p1;
  assign push_entry.fault = fe_fault_e'(icache_fault);

  // ---- request tracking (p1) ----
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      pending_p1 <= 1'b0;
      drop_p1    <= 1'b0;
    end else begin
      if (fe0_valid)  pending_p1 <= 1'b1;
      else if (resp)  pending_p1 <= 1'b0;
      if (flush & pending_p1 & ~icache_ready) drop_p1 <= 1'b1;
      else if (resp)                          drop_p1 <= 1'b0;
    end
  end

  always_ff @(posedge clk_core) begin
    if (fe0_valid) begin
      req_pc_p1   <= fe0_read_addr;
      req_spec_p1 <= fe0_speculative;
    end
  end

  // ---- output queue (p2) ----
  stage_fetch1_queue u_fe1_queue (
    .clk_core   (clk_core),
    .reset_n    (reset_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .clear      (flush),
    .head       (head),
    .count      (count)
  );

  assign fe1_valid       = (count != 2'd0);
  assign fe1_insn        = head.insn;
  assign fe1_pc          = head.pc;
  assign fe1_speculative = head.spec;
  assign fe1_fault       = head.fault;

`ifdef FE1_PERF_EN
  always_ff @(posedge clk_core) begin
    if (!reset_n) begin
      fe1_perf_insn  <= 32'd0;
      fe1_perf_stall <= 32'd0;
    end else begin
      if (pop)       fe1_perf_insn  <= fe1_perf_insn + 32'd1;
      if (fe1_stall) fe1_perf_stall <= fe1_perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stage_fetch1.sv
// Testbench for stage_fetch1: directed scenarios plus randomized traffic against a queue model.
module tb_stage_fetch1;

  logic        clk_core = 1'b0;
  logic        reset_n = 1'b0;
  logic        fe0_valid = 1'b0;
  logic        fe0_speculative = 1'b0;
  logic [29:0] fe0_read_addr = '0;
  logic        icache_ready = 1'b0;
  logic [31:0] icache_data = '0;
  logic [1:0]  icache_fault = '0;
  logic        de_stall = 1'b0;
  logic        de_setpc = 1'b0;
  logic        csr_setpc = 1'b0;
  logic        fe1_stall;
  logic        fe1_valid;
  logic [31:0] fe1_insn;
  logic [29:0] fe1_pc;
  logic        fe1_speculative;
  logic [1:0]  fe1_fault;
`ifdef FE1_PERF_EN
  logic [31:0] fe1_perf_insn;
  logic [31:0] fe1_perf_stall;
`endif

  always #5 clk_core = ~clk_core;

  stage_fetch1 dut (
    .clk_core        (clk_core),
    .reset_n         (reset_n),
`ifdef FE1_PERF_EN
    .fe1_perf_insn   (fe1_perf_insn),
    .fe1_perf_stall  (fe1_perf_stall),
`endif
    .fe0_valid       (fe0_valid),
    .fe0_speculative (fe0_speculative),
    .fe0_read_addr   (fe0_read_addr),
    .fe1_stall       (fe1_stall),
    .icache_ready    (icache_ready),
    .icache_data     (icache_data),
    .icache_fault    (icache_fault),
    .fe1_valid       (fe1_valid),
    .fe1_insn        (fe1_insn),
    .fe1_pc          (fe1_pc),
    .fe1_speculative (fe1_speculative),
    .fe1_fault       (fe1_fault),
    .de_stall        (de_stall),
    .de_setpc        (de_setpc),
    .csr_setpc       (csr_setpc)
  );

  int total = 0;
  int bad = 0;

  // Reference model: a plain list of what decode should see, plus the outstanding request.
  typedef struct packed {
    logic [31:0] insn;
    logic [29:0] pc;
    logic        spec;
    logic [1:0]  fault;
  } ent_t;

  ent_t        mq[$];
  bit          m_pend;
  bit          m_drop;
  bit          m_rspec;
  logic [29:0] m_rpc;
  int unsigned m_pops;
  int unsigned m_stalls;

  function automatic bit model_stall();
    bit fl;
    bit pp;
    int occ;
    fl  = de_setpc || csr_setpc;
    pp  = (mq.size() > 0) && !de_stall && !fl;
    occ = mq.size() - int'(pp) + int'(m_pend && icache_ready && !m_drop);
    return (m_pend && !icache_ready) || (!fl && occ >= 2);
  endfunction

  task automatic model_step();
    bit   fl;
    bit   pp;
    bit   rsp;
    bit   st;
    int   sz;
    ent_t e;
    if (!reset_n) begin
      mq.delete();
      m_pend = 0; m_drop = 0; m_pops = 0; m_stalls = 0;
      return;
    end
    fl  = de_setpc || csr_setpc;
    sz  = mq.size();
    pp  = (sz > 0) && !de_stall && !fl;
    rsp = m_pend && icache_ready;
    st  = model_stall();
    m_stalls += int'(st);
    m_pops   += int'(pp);
    if (fl) mq.delete();
    else begin
      if (pp) void'(mq.pop_front());
      if (rsp && !m_drop) begin
        total++;
        if (sz == 2) begin
          bad++;
          $display("FAIL push_into_full got_count=%0d required_below=2", sz);
        end
        e.insn = icache_data; e.pc = m_rpc; e.spec = m_rspec; e.fault = icache_fault;
        mq.push_back(e);
      end
    end
    if (fl && m_pend && !icache_ready) m_drop = 1;
    else if (rsp)                      m_drop = 0;
    if (fe0_valid) begin
      m_pend = 1; m_rpc = fe0_read_addr; m_rspec = fe0_speculative;
    end else if (rsp) m_pend = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_core);
    #1;
  endtask

  task automatic idle_inputs();
    fe0_valid = 0; fe0_speculative = 0; fe0_read_addr = '0;
    icache_ready = 0; icache_data = '0; icache_fault = '0;
    de_stall = 0; de_setpc = 0; csr_setpc = 0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    idle_inputs();
    repeat (3) tick();
    reset_n = 1;
    #1;
    total++;
    if (fe1_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", fe1_valid); end
    total++;
    if (fe1_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", fe1_stall); end
    total++;
    if ({fe1_insn, fe1_pc, fe1_speculative, fe1_fault} !== 65'd0) begin
      bad++;
      $display("FAIL reset_head got=%h/%h/%b/%0d exp=0", fe1_insn, fe1_pc, fe1_speculative, fe1_fault);
    end
`ifdef FE1_PERF_EN
    total++;
    if ({fe1_perf_insn, fe1_perf_stall} !== 64'd0) begin
      bad++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", fe1_perf_insn, fe1_perf_stall);
    end
`endif
  endtask

  task automatic test_basic();
    idle_inputs();
    fe0_valid = 1; fe0_read_addr = 30'h40;
    tick();
    idle_inputs();
    icache_ready = 1; icache_data = 32'h13;
    #1;
    total++;
    if (fe1_stall !== 1'b0) begin bad++; $display("FAIL basic_stall got=%b exp=0", fe1_stall); end
    tick();
    idle_inputs();
    #1;
    total++;
    if ({fe1_valid, fe1_insn, fe1_pc} !== {1'b1, 32'h13, 30'h40}) begin
      bad++; $display("FAIL basic_head got=%b/%h/%h exp=1/13/40", fe1_valid, fe1_insn, fe1_pc);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 7; i++) begin
      idle_inputs();
      fe0_valid = (i < 6); fe0_read_addr = 30'h200 + 30'(i);
      icache_ready = (i >= 1); icache_data = 32'h1000 + 32'(i - 1);
      #1;
      if (i >= 2) begin
        total++;
        if ({fe1_valid, fe1_stall, fe1_insn, fe1_pc} !==
            {1'b1, 1'b0, 32'h1000 + 32'(i - 2), 30'h200 + 30'(i - 2)}) begin
          bad++;
          $display("FAIL b2b_%0d got=%b/%b/%h/%h exp=1/0/%h/%h", i, fe1_valid, fe1_stall,
                   fe1_insn, fe1_pc, 32'h1000 + 32'(i - 2), 30'h200 + 30'(i - 2));
        end
      end
      tick();
    end
    idle_inputs();
    #1;
    total++;
    if ({fe1_valid, fe1_insn, fe1_pc} !== {1'b1, 32'h1005, 30'h205}) begin
      bad++; $display("FAIL b2b_last got=%b/%h/%h exp=1/1005/205", fe1_valid, fe1_insn, fe1_pc);
    end
    tick();
  endtask

  task automatic test_fill();
    idle_inputs(); de_stall = 1;
    fe0_valid = 1; fe0_read_addr = 30'h300;
    tick();
    idle_inputs(); de_stall = 1;
    icache_ready = 1; icache_data = 32'hA0; fe0_valid = 1; fe0_read_addr = 30'h301;
    tick();
    idle_inputs(); de_stall = 1;
    icache_ready = 1; icache_data = 32'hA1;
    #1;
    total++;
    if (fe1_stall !== 1'b1) begin bad++; $display("FAIL fill_stall_push got=%b exp=1", fe1_stall); end
    tick();
    for (int i = 0; i < 2; i++) begin
      idle_inputs(); de_stall = 1;
      #1;
      total++;
      if ({fe1_stall, fe1_valid, fe1_insn} !== {1'b1, 1'b1, 32'hA0}) begin
        bad++; $display("FAIL fill_hold_%0d got=%b/%b/%h exp=1/1/a0", i, fe1_stall, fe1_valid, fe1_insn);
      end
      tick();
    end
    idle_inputs();
    #1;
    total++;
    if ({fe1_stall, fe1_insn, fe1_pc} !== {1'b0, 32'hA0, 30'h300}) begin
      bad++; $display("FAIL fill_pop0 got=%b/%h/%h exp=0/a0/300", fe1_stall, fe1_insn, fe1_pc);
    end
    tick();
    total++;
    if ({fe1_valid, fe1_insn, fe1_pc} !== {1'b1, 32'hA1, 30'h301}) begin
      bad++; $display("FAIL fill_pop1 got=%b/%h/%h exp=1/a1/301", fe1_valid, fe1_insn, fe1_pc);
    end
    tick();
    total++;
    if (fe1_valid !== 1'b0) begin bad++; $display("FAIL fill_empty got=%b exp=0", fe1_valid); end
  endtask

  task automatic test_flush_drop();
    idle_inputs(); fe0_valid = 1; fe0_read_addr = 30'h400;
    tick();
    idle_inputs(); de_setpc = 1;
    #1;
    total++;
    if (fe1_stall !== 1'b1) begin bad++; $display("FAIL drop_flush_stall got=%b exp=1", fe1_stall); end
    tick();
    idle_inputs();
    #1;
    total++;
    if (fe1_stall !== 1'b1) begin bad++; $display("FAIL drop_wait_stall got=%b exp=1", fe1_stall); end
    tick();
    idle_inputs(); icache_ready = 1; icache_data = 32'hDEADBEEF;
    #1;
    total++;
    if (fe1_stall !== 1'b0) begin bad++; $display("FAIL drop_stale_stall got=%b exp=0", fe1_stall); end
    fe0_valid = 1; fe0_read_addr = 30'h410;
    tick();
    idle_inputs(); icache_ready = 1; icache_data = 32'h33;
    #1;
    total++;
    if (fe1_valid !== 1'b0) begin bad++; $display("FAIL drop_discard got=%b/%h exp=0", fe1_valid, fe1_insn); end
    tick();
    idle_inputs();
    #1;
    total++;
    if ({fe1_valid, fe1_insn, fe1_pc} !== {1'b1, 32'h33, 30'h410}) begin
      bad++; $display("FAIL drop_next got=%b/%h/%h exp=1/33/410", fe1_valid, fe1_insn, fe1_pc);
    end
    tick();
  endtask

  task automatic test_csr_same_cycle();
    idle_inputs(); fe0_valid = 1; fe0_read_addr = 30'h500;
    tick();
    idle_inputs(); de_stall = 1; icache_ready = 1; icache_data = 32'h55;
    fe0_valid = 1; fe0_read_addr = 30'h501;
    tick();
    idle_inputs(); de_stall = 1; csr_setpc = 1; icache_ready = 1; icache_data = 32'h66;
    #1;
    total++;
    if ({fe1_valid, fe1_insn, fe1_stall} !== {1'b1, 32'h55, 1'b0}) begin
      bad++; $display("FAIL csr_before got=%b/%h/%b exp=1/55/0", fe1_valid, fe1_insn, fe1_stall);
    end
    fe0_valid = 1; fe0_read_addr = 30'h502;
    tick();
    idle_inputs(); icache_ready = 1; icache_data = 32'h77;
    #1;
    total++;
    if (fe1_valid !== 1'b0) begin bad++; $display("FAIL csr_cleared got=%b exp=0", fe1_valid); end
    tick();
    idle_inputs();
    #1;
    total++;
    if ({fe1_valid, fe1_insn, fe1_pc} !== {1'b1, 32'h77, 30'h502}) begin
      bad++; $display("FAIL csr_redirect got=%b/%h/%h exp=1/77/502", fe1_valid, fe1_insn, fe1_pc);
    end
    tick();
  endtask

  task automatic test_fault();
    idle_inputs(); fe0_valid = 1; fe0_speculative = 1; fe0_read_addr = 30'h600;
    tick();
    idle_inputs(); icache_ready = 1; icache_data = 32'hBAD; icache_fault = 2'd2;
    fe0_valid = 1; fe0_read_addr = 30'h601;
    tick();
    idle_inputs(); icache_ready = 1; icache_data = 32'h88;
    #1;
    total++;
    if ({fe1_valid, fe1_fault, fe1_speculative, fe1_pc} !== {1'b1, 2'd2, 1'b1, 30'h600}) begin
      bad++; $display("FAIL fault_head got=%b/%0d/%b/%h exp=1/2/1/600", fe1_valid, fe1_fault,
                      fe1_speculative, fe1_pc);
    end
    tick();
    idle_inputs();
    #1;
    total++;
    if ({fe1_valid, fe1_insn, fe1_fault, fe1_speculative, fe1_pc} !==
        {1'b1, 32'h88, 2'd0, 1'b0, 30'h601}) begin
      bad++; $display("FAIL fault_next got=%b/%h/%0d/%b/%h exp=1/88/0/0/601", fe1_valid, fe1_insn,
                      fe1_fault, fe1_speculative, fe1_pc);
    end
    tick();
  endtask

  task automatic test_random();
    bit exp_stall;
    for (int c = 0; c < 3000; c++) begin
      de_setpc     = ($urandom_range(0, 99) < 4);
      csr_setpc    = ($urandom_range(0, 99) < 3);
      de_stall     = ($urandom_range(0, 99) < 30);
      icache_ready = m_pend && ($urandom_range(0, 99) < 60);
      icache_data  = $urandom;
      icache_fault = 2'($urandom_range(0, 2));
      exp_stall    = model_stall();
      fe0_valid    = !exp_stall && ($urandom_range(0, 99) < 70);
      fe0_read_addr   = 30'($urandom);
      fe0_speculative = 1'($urandom);
      #1;
      total++;
      if ({fe1_valid, fe1_stall} !== {mq.size() != 0, exp_stall}) begin
        bad++; $display("FAIL rnd_ctl_%0d got=%b/%b exp=%b/%b", c, fe1_valid, fe1_stall,
                        mq.size() != 0, exp_stall);
      end
      if (mq.size() != 0) begin
        total++;
        if ({fe1_insn, fe1_pc, fe1_speculative, fe1_fault} !== mq[0]) begin
          bad++; $display("FAIL rnd_head_%0d got=%h/%h/%b/%0d exp=%h/%h/%b/%0d", c, fe1_insn, fe1_pc,
                          fe1_speculative, fe1_fault, mq[0].insn, mq[0].pc, mq[0].spec, mq[0].fault);
        end
      end
      tick();
    end
    idle_inputs();
`ifdef FE1_PERF_EN
    total++;
    if ({fe1_perf_insn, fe1_perf_stall} !== {m_pops, m_stalls}) begin
      bad++; $display("FAIL rnd_perf got=%0d/%0d exp=%0d/%0d", fe1_perf_insn, fe1_perf_stall,
                      m_pops, m_stalls);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_fill();
    test_flush_drop();
    test_csr_same_cycle();
    test_fault();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
